muladd_exec_unit: RTL and testbench
===================================

Name: muladd_exec_unit

Overview:
- Consumer end of the source-3 operand path: the execution unit that receives the value routed to source3_muladd_cont.
- Also receives source 1 and source 2.
- Computes the signed fused result src1*src2 + src3 in a 3-stage valid/ready pipeline.
- Returns the result with an issue tag and an overflow flag to writeback.

Parameters:
- WORD_SIZE, default `WORD_SIZE (32): operand and result width.
- TAG_WIDTH, default 4: width of the destination/issue tag carried alongside the operands.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all in-flight operations.
- in_valid  input  1  operand set present.
- in_ready  output  1  unit accepts the operand set this cycle.
- src1_value  input  WORD_SIZE  multiplicand, signed two's complement.
- src2_value  input  WORD_SIZE  multiplier, signed.
- source3_muladd_cont  input  WORD_SIZE  addend from the source-3 value mux, signed.
- in_tag  input  TAG_WIDTH  issue tag.
- out_valid  output  1  result present.
- out_ready  input  1  writeback accepts the result.
- result  output  WORD_SIZE  computed value.
- out_tag  output  TAG_WIDTH  tag of the result.
- ovf  output  1  true signed result is not representable in WORD_SIZE bits.
- busy  output  1  any stage valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valids, out_valid, ovf, busy = 0;
  - result and out_tag = 0.
  - Reset mid-operation discards every operation; no partial result appears after release.
- Handshake:
  - An operand set transfers on a rising edge with in_valid && in_ready.
  - A result transfers on out_valid && out_ready.
  - result, out_tag and ovf hold stable while out_valid && !out_ready.
- Pipeline: S1 operand register -> S2 product register -> S3 output register; S3 drives the outputs directly.
  - S1 captures the operands and in_tag.
  - S2 holds the full 2*WORD_SIZE signed product, the addend and the tag.
  - S3 holds the sign-extended sum and the flag.
- Latency: exactly 3 cycles from accept edge to out_valid, with no backpressure.
- Throughput: 1 per cycle.
- Stall rules:
  - Stage k advances when stage k+1 is empty or advancing.
  - S3 advances when out_ready.
  - in_ready = !s1_valid || s1_advance (combinational from out_ready through the stages; no skid buffer).
  - Bubbles collapse: a stalled S3 lets empty earlier stages fill.
- Arithmetic:
  - sum = sext(product, 2W+1) + sext(src3, 2W+1).
  - ovf = 1 when sum lies outside [-2^(W-1), 2^(W-1)-1].
  - result = sum[W-1:0] (wrap).
- flush:
  - All valids clear on the next edge.
  - in_ready is forced 0 during the flush cycle, and no input is accepted that cycle.
  - flush overrides a simultaneous out_ready or in_valid; a result with out_valid && out_ready in the flush cycle still counts as delivered.
- busy = s1_valid | s2_valid | s3_valid.

Optional Feature:
- Macro: MULADD_SAT_EN.
- Defined: when ovf = 1, result clamps to 2^(W-1)-1 (positive overflow) or -2^(W-1) (negative overflow); ovf still reports the event.
- Undefined: result wraps modulo 2^W; the ovf behaviour is identical.
- Latency is unaffected in both builds.

Decomposition:
- In defines.vh: WORD_SIZE, TAG_WIDTH default, and localparams for the signed max/min constants.
- One sub-module, muladd_pipe_reg: a parameterised valid/data stage register with advance/flush logic, instantiated 3 times.

Test Plan (WORD_SIZE = 32):
- Basic: src1=3, src2=-4, src3=100, tag=5, out_ready=1 held -> 3 cycles later result=88, out_tag=5, ovf=0.
- Streaming: 8 back-to-back sets with out_ready=1 -> in_ready stays 1 and 8 results arrive in order on consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles while feeding -> at most 3 accepted; out_valid data stays stable; release returns all in order with no loss or duplication.
- Overflow: src1=0x7FFFFFFF, src2=2, src3=0 -> ovf=1:
  - without MULADD_SAT_EN, result=0xFFFFFFFE;
  - with it, result=0x7FFFFFFF.
  - src1=0x80000000, src2=1, src3=-1 -> ovf=1; saturated result=0x80000000.
- Flush and reset: with 3 ops in flight, pulse flush -> next cycle busy=0, out_valid=0, no stale result later. Repeat with rst_n low asynchronously mid-cycle -> outputs 0 immediately.

Source files
------------

// File: rtl/muladd_exec_unit_pkg.sv
// Shared defaults for the fused multiply-add execution unit.
// WORD_SIZE may be overridden on the command line; it defaults to 32.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package muladd_exec_unit_pkg;

    localparam int unsigned WordSizeDflt = `WORD_SIZE;
    localparam int unsigned TagWidthDflt = 4;

endpackage

// File: rtl/muladd_pipe_reg.sv
// One valid/data pipeline stage. It loads when empty or when the downstream stage takes its
// contents, and it drops its contents on flush.
module muladd_pipe_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    input  logic             ready_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    always_comb begin
        ready_o = !valid_q || ready_i;
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (ready_o) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/muladd_exec_unit.sv
// Three-stage signed src1*src2 + src3 execution unit with a tag and an overflow flag.
// Define MULADD_SAT_EN to clamp overflowing results instead of wrapping them.
module muladd_exec_unit
    import muladd_exec_unit_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WordSizeDflt,
    parameter int unsigned TAG_WIDTH = TagWidthDflt
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] src1_value,
    input  logic [WORD_SIZE-1:0] src2_value,
    input  logic [WORD_SIZE-1:0] source3_muladd_cont,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] result,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 ovf,
    output logic                 busy
);

    localparam int unsigned W   = WORD_SIZE;
    localparam int unsigned S1W = 3 * W + TAG_WIDTH;
    localparam int unsigned S2W = 3 * W + TAG_WIDTH;
    localparam int unsigned S3W = W + 1 + TAG_WIDTH;

`ifdef MULADD_SAT_EN
    localparam logic [W-1:0] SignedMax = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0] SignedMin = {1'b1, {(W - 1){1'b0}}};
`endif

    logic           s1_ready, s1_valid;
    logic           s2_ready, s2_valid;
    logic           s3_ready, s3_valid;
    logic [S1W-1:0] s1_data_in, s1_data;
    logic [S2W-1:0] s2_data_in, s2_data;
    logic [S3W-1:0] s3_data_in, s3_data;

    // Flush blocks acceptance in the same cycle it clears the stages.
    assign in_ready   = s1_ready && !flush;
    assign s1_data_in = {src1_value, src2_value, source3_muladd_cont, in_tag};

    muladd_pipe_reg #(.Width(S1W)) u_s1 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .valid_i (in_valid),
        .data_i  (s1_data_in),
        .ready_i (s2_ready),
        .ready_o (s1_ready),
        .valid_o (s1_valid),
        .data_o  (s1_data)
    );

    logic signed [W-1:0]   s1_a, s1_b;
    logic signed [2*W-1:0] s1_prod;

    always_comb begin
        s1_a       = s1_data[S1W-1 -: W];
        s1_b       = s1_data[S1W-W-1 -: W];
        s1_prod    = s1_a * s1_b;
        s2_data_in = {s1_prod, s1_data[W+TAG_WIDTH-1:0]};
    end

    muladd_pipe_reg #(.Width(S2W)) u_s2 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .valid_i (s1_valid),
        .data_i  (s2_data_in),
        .ready_i (s3_ready),
        .ready_o (s2_ready),
        .valid_o (s2_valid),
        .data_o  (s2_data)
    );

    logic [2*W-1:0] s2_prod;
    logic [W-1:0]   s2_addend;
    logic [2*W:0]   s2_sum;
    logic           s2_ovf;
    logic [W-1:0]   s2_res;

    always_comb begin
        s2_prod   = s2_data[S2W-1 -: 2*W];
        s2_addend = s2_data[W+TAG_WIDTH-1 -: W];
        s2_sum    = {s2_prod[2*W-1], s2_prod} + {{(W + 1){s2_addend[W-1]}}, s2_addend};
        // Representable iff every bit from the sign down to bit W-1 agrees.
        s2_ovf    = !((&s2_sum[2*W:W-1]) || !(|s2_sum[2*W:W-1]));
        s2_res    = s2_sum[W-1:0];
`ifdef MULADD_SAT_EN
        if (s2_ovf) begin
            s2_res = s2_sum[2*W] ? SignedMin : SignedMax;
        end
`endif
        s3_data_in = {s2_res, s2_ovf, s2_data[TAG_WIDTH-1:0]};
    end

    muladd_pipe_reg #(.Width(S3W)) u_s3 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .valid_i (s2_valid),
        .data_i  (s3_data_in),
        .ready_i (out_ready),
        .ready_o (s3_ready),
        .valid_o (s3_valid),
        .data_o  (s3_data)
    );

    assign out_valid = s3_valid;
    assign result    = s3_data[S3W-1 -: W];
    assign ovf       = s3_data[TAG_WIDTH];
    assign out_tag   = s3_data[TAG_WIDTH-1:0];
    assign busy      = s1_valid | s2_valid | s3_valid;

endmodule

// File: tb/tb_muladd_exec_unit.sv
// Directed self-checking bench for muladd_exec_unit (WORD_SIZE = 32, TAG_WIDTH = 4).
module tb_muladd_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] src1_value = '0;
    logic [31:0] src2_value = '0;
    logic [31:0] source3_muladd_cont = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [3:0]  out_tag;
    logic        ovf;
    logic        busy;

    int checks = 0;
    int passed = 0;

    muladd_exec_unit #(.WORD_SIZE(32), .TAG_WIDTH(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush               (flush),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .src1_value          (src1_value),
        .src2_value          (src2_value),
        .source3_muladd_cont (source3_muladd_cont),
        .in_tag              (in_tag),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .result              (result),
        .out_tag             (out_tag),
        .ovf                 (ovf),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, want finished)");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result); else passed++;
        checks++; if (out_tag !== 4'h0) $display("FAIL reset_tag: got %h want 0", out_tag); else passed++;
        checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        in_valid = 1'b1;
        src1_value = 32'd3;
        src2_value = -32'sd4;
        source3_muladd_cont = 32'd100;
        in_tag = 4'd5;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready: got %b want 1", in_ready); else passed++;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_lat1: got %b want 0", out_valid); else passed++;
        step();
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_lat2: got %b want 0", out_valid); else passed++;
        step();
        checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_valid); else passed++;
        checks++; if (result !== 32'd88) $display("FAIL basic_result: got %0d want 88", result); else passed++;
        checks++; if (out_tag !== 4'd5) $display("FAIL basic_tag: got %0d want 5", out_tag); else passed++;
        checks++; if (ovf !== 1'b0) $display("FAIL basic_ovf: got %b want 0", ovf); else passed++;
        step();
        checks++; if (busy !== 1'b0) $display("FAIL basic_drained: got busy=%b want 0", busy); else passed++;
    endtask

    task automatic test_streaming();
        int rx = 0;
        int first = -1;
        int last = -1;
        bit rdy_ok = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) begin
                in_valid = 1'b1;
                src1_value = 32'(c + 1);
                src2_value = 32'(c - 3);
                source3_muladd_cont = 32'(100 * c);
                in_tag = 4'(c);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 8 && in_ready !== 1'b1) rdy_ok = 1'b0;
            step();
            if (out_valid === 1'b1) begin
                if (rx < 8) begin
                    int e;
                    e = (rx + 1) * (rx - 3) + 100 * rx;
                    checks++;
                    if (result !== 32'(e) || out_tag !== 4'(rx))
                        $display("FAIL stream_item%0d: got %0d tag %0d want %0d tag %0d",
                                 rx, $signed(result), out_tag, e, rx);
                    else passed++;
                end
                if (first < 0) first = c;
                last = c;
                rx++;
            end
        end
        checks++; if (rdy_ok !== 1'b1) $display("FAIL stream_in_ready: got dropped want held 1"); else passed++;
        checks++; if (rx != 8) $display("FAIL stream_count: got %0d want 8", rx); else passed++;
        checks++; if (first != 2) $display("FAIL stream_first: got cycle %0d want 2", first); else passed++;
        checks++; if (last != 9) $display("FAIL stream_last: got cycle %0d want 9", last); else passed++;
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int rx = 0;
        bit held = 1'b0;
        bit stable = 1'b1;
        logic [31:0] held_res;
        logic [3:0]  held_tag;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            src1_value = 32'(acc + 2);
            src2_value = 32'd3;
            source3_muladd_cont = 32'(-acc);
            in_tag = 4'(acc);
            #1;
            if (in_ready === 1'b1) acc++;
            step();
            if (out_valid === 1'b1) begin
                if (!held) begin
                    held = 1'b1;
                    held_res = result;
                    held_tag = out_tag;
                end else if (result !== held_res || out_tag !== held_tag) begin
                    stable = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (acc != 3) $display("FAIL bp_accepted: got %0d want 3", acc); else passed++;
        checks++; if (!(held && stable)) $display("FAIL bp_stable: got held=%b stable=%b want 1 1", held, stable); else passed++;
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (result !== 32'(2 * rx + 6) || out_tag !== 4'(rx))
                    $display("FAIL bp_item%0d: got %0d tag %0d want %0d tag %0d",
                             rx, result, out_tag, 2 * rx + 6, rx);
                else passed++;
                rx++;
            end
            step();
        end
        checks++; if (rx != 3) $display("FAIL bp_drain_count: got %0d want 3", rx); else passed++;
    endtask

    task automatic test_overflow();
        logic [31:0] a [5];
        logic [31:0] b [5];
        logic [31:0] c3 [5];
        logic [31:0] er [5];
        logic        eo [5];
        int rx = 0;
        a[0] = 32'h7FFFFFFF; b[0] = 32'd2;        c3[0] = 32'd0;        eo[0] = 1'b1;
        a[1] = 32'h80000000; b[1] = 32'd1;        c3[1] = 32'hFFFFFFFF; eo[1] = 1'b1;
        a[2] = 32'h7FFFFFFF; b[2] = 32'd1;        c3[2] = 32'd0;        eo[2] = 1'b0;
        a[3] = 32'h80000000; b[3] = 32'd1;        c3[3] = 32'd0;        eo[3] = 1'b0;
        a[4] = 32'hFFFFFFFF; b[4] = 32'h80000000; c3[4] = 32'd0;        eo[4] = 1'b1;
`ifdef MULADD_SAT_EN
        er[0] = 32'h7FFFFFFF; er[1] = 32'h80000000; er[4] = 32'h7FFFFFFF;
`else
        er[0] = 32'hFFFFFFFE; er[1] = 32'h7FFFFFFF; er[4] = 32'h80000000;
`endif
        er[2] = 32'h7FFFFFFF; er[3] = 32'h80000000;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 5) begin
                in_valid = 1'b1;
                src1_value = a[c];
                src2_value = b[c];
                source3_muladd_cont = c3[c];
                in_tag = 4'(c + 8);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (out_valid === 1'b1 && rx < 5) begin
                checks++;
                if (result !== er[rx] || ovf !== eo[rx] || out_tag !== 4'(rx + 8))
                    $display("FAIL ovf_item%0d: got %h ovf %b tag %0d want %h ovf %b tag %0d",
                             rx, result, ovf, out_tag, er[rx], eo[rx], rx + 8);
                else passed++;
                rx++;
            end
        end
        checks++; if (rx != 5) $display("FAIL ovf_count: got %0d want 5", rx); else passed++;
    endtask

    task automatic test_flush();
        bit stale = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            src1_value = 32'(c + 1);
            src2_value = 32'd2;
            source3_muladd_cont = 32'd1;
            in_tag = 4'(c);
            step();
        end
        checks++; if (busy !== 1'b1) $display("FAIL flush_pre_busy: got %b want 1", busy); else passed++;
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", in_ready); else passed++;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", out_valid); else passed++;
        for (int c = 0; c < 5; c++) begin
            step();
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        checks++; if (stale) $display("FAIL flush_stale: got stale result want none"); else passed++;
    endtask

    task automatic test_async_reset();
        bit stale = 1'b0;
        out_ready = 1'b0;
        src1_value = 32'd5;
        src2_value = 32'd7;
        source3_muladd_cont = 32'd1;
        in_tag = 4'd9;
        in_valid = 1'b1;
        step();
        step();
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 32'd36)
            $display("FAIL arst_pre: got valid %b result %0d want 1 36", out_valid, result);
        else passed++;
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy); else passed++;
        checks++; if (result !== 32'h0) $display("FAIL arst_result: got %h want 0", result); else passed++;
        checks++; if (out_tag !== 4'h0) $display("FAIL arst_tag: got %h want 0", out_tag); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        checks++; if (stale) $display("FAIL arst_stale: got stale result want none"); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_streaming();
        test_backpressure();
        test_overflow();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
